// File: rtl/start_sequencer_pkg.sv
// Shared state encoding and default timing constants for the Start launch sequencer.
package start_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        RUN    = 3'd2,
        REPORT = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam int unsigned NUM_PROG_DEF    = 3;
    localparam int unsigned PULSE_LEN_DEF   = 2;
    localparam int unsigned GAP_LEN_DEF     = 4;
    localparam int unsigned CW_DEF          = 16;
    localparam int unsigned TIMEOUT_CYC_DEF = 4000;

    // Width of the shared PULSE/GAP phase timer.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/start_sequencer_if.sv
// Control/handshake bundle between harness control, the sequencer and the processor pins.
interface start_sequencer_if
    import start_seq_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
);
    logic          Go;
    logic          Done;
    logic          Start;
    logic [1:0]    ProgIdx;
    logic          Busy;
    logic [CW-1:0] CycleCount;
    logic          CountValid;
    logic          AllDone;
    logic          TimedOut;

    modport master (
        output Go, Done,
        input  Start, ProgIdx, Busy, CycleCount, CountValid, AllDone, TimedOut
    );

    modport slave (
        input  Go, Done,
        output Start, ProgIdx, Busy, CycleCount, CountValid, AllDone, TimedOut
    );
endinterface

// File: rtl/start_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear and enable, sync active-low reset.
module sat_counter #(
    parameter int unsigned CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count
);
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/start_sequencer.sv
// Start-pulse launch sequencer: pulses Start per program, measures RUN cycles to Done.
// Optional watchdog enabled by defining START_SEQ_TIMEOUT_EN.
module start_sequencer
    import start_seq_pkg::*;
#(
    parameter int unsigned NUM_PROG    = NUM_PROG_DEF,
    parameter int unsigned PULSE_LEN   = PULSE_LEN_DEF,
    parameter int unsigned GAP_LEN     = GAP_LEN_DEF,
    parameter int unsigned CW          = CW_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input logic              Clk,
    input logic              Reset,
    start_sequencer_if.slave bus
);
    localparam int unsigned TW = timer_width(PULSE_LEN, GAP_LEN);

    if (PULSE_LEN < 1 || GAP_LEN < 1 || NUM_PROG < 1 || NUM_PROG > 3 ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (64'd1 << CW)) begin : g_cfg_err
        $error("start_sequencer: unsupported parameter set");
    end

    state_t          state, state_nxt;
    logic [TW-1:0]   tmr;
    logic            tmr_last;
    logic            done_q;
    logic            done_rise;
    logic            run_tmo;
    logic [CW-1:0]   run_cnt;
    logic            start_r;
    logic            busy_r;
    logic            cv_r;
    logic            alldone_r;
    logic [1:0]      prog_r;
    logic [CW-1:0]   cyc_r;

    assign done_rise = bus.Done & ~done_q;
    assign tmr_last  = (state == PULSE) ? (tmr == TW'(PULSE_LEN - 1))
                                        : (tmr == TW'(GAP_LEN - 1));

    sat_counter #(.CW(CW)) u_run_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   ((state == PULSE) && tmr_last),
        .en    (state == RUN),
        .count (run_cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.Go) state_nxt = PULSE;
            PULSE:   if (tmr_last) state_nxt = RUN;
            RUN:     if (done_rise || run_tmo) state_nxt = REPORT;
            REPORT:  state_nxt = (prog_r == 2'(NUM_PROG)) ? IDLE : GAP;
            GAP:     if (tmr_last) state_nxt = PULSE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output flops are loaded from the next state so every output is registered.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= IDLE;
            tmr       <= '0;
            done_q    <= 1'b0;
            start_r   <= 1'b0;
            busy_r    <= 1'b0;
            cv_r      <= 1'b0;
            alldone_r <= 1'b0;
            prog_r    <= '0;
            cyc_r     <= '0;
        end else begin
            state   <= state_nxt;
            done_q  <= bus.Done;
            start_r <= (state_nxt == PULSE);
            busy_r  <= (state_nxt != IDLE);
            cv_r    <= (state_nxt == REPORT);

            if (state_nxt != state) begin
                tmr <= '0;
            end else if (state == PULSE || state == GAP) begin
                tmr <= tmr + 1'b1;
            end

            if (state == RUN && state_nxt == REPORT) begin
                cyc_r <= run_cnt;
            end

            if (state == IDLE && bus.Go) begin
                prog_r    <= 2'd1;
                alldone_r <= 1'b0;
            end else if (state == GAP && state_nxt == PULSE) begin
                prog_r <= prog_r + 1'b1;
            end else if (state == REPORT && state_nxt == IDLE) begin
                prog_r    <= '0;
                alldone_r <= 1'b1;
            end
        end
    end

`ifdef START_SEQ_TIMEOUT_EN
    logic timed_out_r;

    assign run_tmo = (run_cnt == CW'(TIMEOUT_CYC));

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            timed_out_r <= 1'b0;
        end else if (state == IDLE && bus.Go) begin
            timed_out_r <= 1'b0;
        end else if (state == RUN && run_tmo && !done_rise) begin
            timed_out_r <= 1'b1;
        end
    end

    assign bus.TimedOut = timed_out_r;
`else
    assign run_tmo      = 1'b0;
    assign bus.TimedOut = 1'b0;
`endif

    assign bus.Start      = start_r;
    assign bus.ProgIdx    = prog_r;
    assign bus.Busy       = busy_r;
    assign bus.CycleCount = cyc_r;
    assign bus.CountValid = cv_r;
    assign bus.AllDone    = alldone_r;
endmodule

// File: tb/tb_start_sequencer.sv
// Directed self-checking bench for start_sequencer; watchdog scenario built only with START_SEQ_TIMEOUT_EN.
module tb_start_sequencer;
    import start_seq_pkg::*;

    localparam int unsigned CW  = 16;
    localparam int unsigned PL  = 2;
    localparam int unsigned GL  = 4;
    localparam int unsigned TMO = 50;

    logic Clk = 1'b0;
    logic Reset;

    start_sequencer_if #(.CW(CW)) bus ();

    start_sequencer #(
        .NUM_PROG    (3),
        .PULSE_LEN   (PL),
        .GAP_LEN     (GL),
        .CW          (CW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_start"}, 32'(bus.Start), 0);
        check_val({tag, "_busy"}, 32'(bus.Busy), 0);
        check_val({tag, "_prog"}, 32'(bus.ProgIdx), 0);
        check_val({tag, "_cv"}, 32'(bus.CountValid), 0);
    endtask

    // Go sampled at the next edge; returns in pulse cycle 1 of program 1.
    task automatic launch();
        bus.Go = 1'b1;
        step();
        bus.Go = 1'b0;
        check_val("launch_alldone_clr", 32'(bus.AllDone), 0);
        check_val("launch_tmo_clr", 32'(bus.TimedOut), 0);
    endtask

    // Entered in pulse cycle 1 of program k; Done rises at RUN cycle r unless tmo.
    task automatic run_prog(input int k, input int r, input bit last,
                            input int drop_at, input int go_at, input bit tmo);
        for (int p = 0; p < int'(PL); p++) begin
            check_val("pulse_start", 32'(bus.Start), 1);
            check_val("pulse_prog", 32'(bus.ProgIdx), 32'(k));
            check_val("pulse_busy", 32'(bus.Busy), 1);
            step();
        end
        for (int i = 0; i < r; i++) begin
            check_val("run_start", 32'(bus.Start), 0);
            check_val("run_cv", 32'(bus.CountValid), 0);
            check_val("run_prog", 32'(bus.ProgIdx), 32'(k));
            if (i == drop_at) bus.Done = 1'b0;
            bus.Go = (i == go_at);
            step();
        end
        bus.Go = 1'b0;
        if (!tmo) bus.Done = 1'b1;
        check_val("run_end_cv", 32'(bus.CountValid), 0);
        step();
        check_val("report_cv", 32'(bus.CountValid), 1);
        check_val("report_count", 32'(bus.CycleCount), 32'(r));
        check_val("report_busy", 32'(bus.Busy), 1);
        if (tmo) check_val("report_timedout", 32'(bus.TimedOut), 1);
        bus.Done = 1'b0;
        step();
        if (last) begin
            check_idle_outputs("end");
            check_val("end_alldone", 32'(bus.AllDone), 1);
            check_val("end_count_hold", 32'(bus.CycleCount), 32'(r));
        end else begin
            for (int g = 0; g < int'(GL); g++) begin
                check_val("gap_start", 32'(bus.Start), 0);
                check_val("gap_cv", 32'(bus.CountValid), 0);
                check_val("gap_prog", 32'(bus.ProgIdx), 32'(k));
                step();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got=expired expected=finished");
        $fatal(1, "time limit");
    end

    initial begin
        Reset   = 1'b0;
        bus.Go   = 1'b1;
        bus.Done = 1'b0;

        // reset held with Go high: nothing may launch
        for (int c = 0; c < 3; c++) begin
            step();
            check_idle_outputs("rst");
            check_val("rst_count", 32'(bus.CycleCount), 0);
            check_val("rst_alldone", 32'(bus.AllDone), 0);
            check_val("rst_tmo", 32'(bus.TimedOut), 0);
        end
        bus.Go = 1'b0;
        Reset  = 1'b1;
        step();
        check_idle_outputs("post_rst");

        // full three-program sequence
        launch();
        run_prog(1, 10, 1'b0, -1, -1, 1'b0);
        run_prog(2, 25, 1'b0, -1, -1, 1'b0);
        run_prog(3, 7, 1'b1, -1, -1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check_val("idle_alldone_sticky", 32'(bus.AllDone), 1);
            check_val("idle_start", 32'(bus.Start), 0);
        end
        check_val("seq_tmo_zero", 32'(bus.TimedOut), 0);

        // stale Done high through IDLE and launch; Go pulsed while busy
        bus.Done = 1'b1;
        step();
        step();
        check_idle_outputs("stale_idle");
        launch();
        run_prog(1, 9, 1'b0, 3, -1, 1'b0);
        run_prog(2, 5, 1'b0, -1, 2, 1'b0);
        run_prog(3, 3, 1'b1, -1, -1, 1'b0);

        // reset during the first pulse
        launch();
        check_val("midrst_start_before", 32'(bus.Start), 1);
        Reset = 1'b0;
        step();
        check_idle_outputs("midrst");
        Reset = 1'b1;
        step();
        check_idle_outputs("midrst_after");
        launch();
        run_prog(1, 1, 1'b0, -1, -1, 1'b0);
        run_prog(2, 2, 1'b0, -1, -1, 1'b0);
        run_prog(3, 3, 1'b1, -1, -1, 1'b0);

`ifdef START_SEQ_TIMEOUT_EN
        launch();
        run_prog(1, 5, 1'b0, -1, -1, 1'b0);
        run_prog(2, int'(TMO), 1'b0, -1, -1, 1'b1);
        run_prog(3, 4, 1'b1, -1, -1, 1'b0);
        check_val("wdog_tmo_sticky", 32'(bus.TimedOut), 1);
`else
        check_val("no_wdog_tmo", 32'(bus.TimedOut), 0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
